// File: rtl/keen_pkg.sv
// -----------------------------------------------------------------------------
// keen_pkg -- shared definitions for the chunk-serial adder.
//   state_e : controller states (IDLE/RUN/DONE) with fixed encodings
//   idx_w() : width of a chunk index for n chunks, never less than 1 bit
// -----------------------------------------------------------------------------
package keen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/keen_adder.sv
// -----------------------------------------------------------------------------
// keen_adder -- one XLEN-bit ripple chunk of the serial adder.
//   i_a, i_b : chunk operands
//   i_c      : carry in
//   o_s      : chunk sum
//   o_c      : carry out
// -----------------------------------------------------------------------------
module keen_adder #(
  parameter int XLEN = 8
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic            i_c,
  output logic [XLEN-1:0] o_s,
  output logic            o_c
);

  logic [XLEN:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{XLEN{1'b0}}, i_c};
  assign o_s    = w_full[XLEN-1:0];
  assign o_c    = w_full[XLEN];

endmodule

// File: rtl/keen_adder_seq.sv
// -----------------------------------------------------------------------------
// keen_adder_seq -- WIDTH-bit adder that reuses one XLEN-bit chunk adder over
// CHUNKS cycles. Result appears CHUNKS cycles after the operand accept.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous abort, wins over any handshake
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   a, b, c_in          : operands and carry-in
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, c_out          : registered result
//   ovf                 : two's-complement overflow, only when the macro
//                         KEEN_ADDER_SEQ_OVF_EN is defined
// -----------------------------------------------------------------------------
module keen_adder_seq
  import keen_pkg::*;
#(
  parameter  int XLEN   = 8,
  parameter  int CHUNKS = 4,
  localparam int WIDTH  = XLEN * CHUNKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef KEEN_ADDER_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IDXW = idx_w(CHUNKS);

  state_e                      r_state, w_next;
  logic [IDXW-1:0]             r_idx;
  logic                        r_carry;
  logic [CHUNKS-1:0][XLEN-1:0] r_a, r_b, r_sum;
  logic                        r_cout;

  logic [XLEN-1:0] w_ca, w_cb, w_cs;
  logic            w_co, w_last;

  assign w_ca   = r_a[r_idx];
  assign w_cb   = r_b[r_idx];
  assign w_last = (r_idx == IDXW'(CHUNKS - 1));

  keen_adder #(.XLEN(XLEN)) u_add (
    .i_a (w_ca),
    .i_b (w_cb),
    .i_c (r_carry),
    .o_s (w_cs),
    .o_c (w_co)
  );

  // ---------------- controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN:  if (w_last) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (flush) w_next = IDLE;
  end

  // ---------------- datapath ----------------
  // sum/c_out only change in RUN, so they hold steady through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (!flush) begin
      if (r_state == IDLE && in_valid) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= c_in;
        r_idx   <= '0;
      end else if (r_state == RUN) begin
        r_sum[r_idx] <= w_cs;
        r_carry      <= w_co;
        r_idx        <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) r_cout <= w_co;
      end
    end
  end

  assign sum   = r_sum;
  assign c_out = r_cout;

`ifdef KEEN_ADDER_SEQ_OVF_EN
  // Carry into the top bit is recovered from the top chunk's MSB sum bit.
  logic r_ovf;
  logic w_cmsb;

  assign w_cmsb = w_ca[XLEN-1] ^ w_cb[XLEN-1] ^ w_cs[XLEN-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_ovf <= 1'b0;
    else if (!flush && r_state == RUN && w_last)
      r_ovf <= w_cmsb ^ w_co;
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: doc/keen_adder_seq.md
KEEN_ADDER_SEQ -- requirements
Module: keen_adder_seq

Interface
REQ-001 SHALL have parameter XLEN, default 8, meaning the width of one adder chunk in bits.
REQ-002 SHALL have parameter CHUNKS, default 4, meaning the number of chunks per operand.
REQ-003 SHALL derive a local constant WIDTH = XLEN*CHUNKS, the operand width; it is not overridable.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1 bit: synchronous abort.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the operand handshake.
REQ-008 SHALL have ports a and b (input, WIDTH each) and c_in (input, 1): the operands and carry-in.
REQ-009 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-010 SHALL have ports sum (output, WIDTH) and c_out (output, 1): the result.
REQ-011 SHALL have port ovf, output, 1 bit: two's-complement overflow; present only under KEEN_ADDER_SEQ_OVF_EN.

Function
REQ-012 SHALL implement three states: IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE.
REQ-014 SHALL accept an operand set when in_valid&&in_ready at a clock edge: latch a, b and c_in, clear the chunk index to 0, and move to RUN.
REQ-015 SHALL, in RUN, add chunk[idx] of a and b plus the carry register through one XLEN-bit adder, store the result into sum[idx], update the carry register, and increment idx.
REQ-016 SHALL move from RUN to DONE on the edge that processes chunk CHUNKS-1.
REQ-017 SHALL assert out_valid exactly CHUNKS cycles after the accept edge; with CHUNKS=1, one cycle after accept.
REQ-018 SHALL assert out_valid only in DONE, holding sum and c_out stable until out_valid&&out_ready.
REQ-019 SHALL, on out_valid&&out_ready, return to IDLE; the next accept is possible on the following edge.
REQ-020 SHALL ignore out_ready outside DONE, and ignore changes on a, b, c_in and in_valid outside IDLE.
REQ-021 SHALL produce sum = (a+b+c_in) mod 2^WIDTH, with c_out equal to bit WIDTH of that sum.
REQ-022 SHALL drive sum and c_out from registers only, with no combinational path from any input.
REQ-023 SHALL, when flush=1 at an edge, force IDLE, clear out_valid and discard the operation, in any state.
REQ-024 SHALL give flush priority over a simultaneous in_valid accept or out_ready handshake.

Reset
REQ-025 SHALL, while rst_n=0, immediately force state=IDLE, idx=0, carry=0, sum=0, c_out=0, out_valid=0 and ovf=0, with in_ready=1.
REQ-026 SHALL, on reset asserted mid-RUN or in DONE, abandon the result; nothing is emitted after release.

Configuration
REQ-027 SHALL, with KEEN_ADDER_SEQ_OVF_EN defined, register ovf = carry into bit WIDTH-1 XOR c_out, valid with out_valid.
REQ-028 SHALL, without KEEN_ADDER_SEQ_OVF_EN, have no ovf port and no overflow logic.

Structure
REQ-029 SHALL take the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) from the shared package keen_pkg.
REQ-030 SHALL instantiate exactly one keen_adder with XLEN=XLEN as its only sub-module, carrying the chunk datapath.
REQ-031 SHALL size idx to $clog2(CHUNKS), with a minimum of 1 bit.

Verification (XLEN=8, CHUNKS=4)
REQ-032 SHALL check: a=32'hFFFFFFFF, b=1, c_in=0 -> sum=0, c_out=1, out_valid exactly 4 cycles after accept.
REQ-033 SHALL check: a=32'h12345678, b=32'h11111111, c_in=1 -> sum=32'h2345678A, c_out=0; with OVF_EN, ovf=0.
REQ-034 SHALL check: a=32'h7FFFFFFF, b=1, c_in=0 with OVF_EN -> sum=32'h80000000, ovf=1, c_out=0.
REQ-035 SHALL check: out_ready held 0 for 5 cycles in DONE -> sum stable, in_ready=0; out_ready=1 -> IDLE next edge.
REQ-036 SHALL check: flush at the RUN cycle with idx=2 -> IDLE next edge, out_valid never asserted; the next operation adds correctly.
REQ-037 SHALL check: rst_n pulsed low mid-RUN -> all outputs at reset values immediately, in_ready=1 after release.
